sram_cache_controller: RTL

//  2-way set-associative, 1-word-line, write-through/no-write-allocate cache between
//  the MEM stage and the SRAM controller. Read hits return data in the same cycle with
//  no stall. Misses and all writes go to the SRAM controller. The block freezes the

---
 rtl/sram_cache_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sram_cache_controller.sv
`default_nettype none
// ============================================================================
// sram_cache_controller : 2-way set-associative write-through cache in front
//                         of the SRAM controller, freezing the pipeline on miss
// Revision 1.0 - initial release
// ============================================================================
module sram_cache_controller #(
   parameter int SET_BITS = 6,
   parameter int TAG_W    = 17 - SET_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        freeze,
   output logic        sram_rd_en,
   output logic        sram_wr_en,
   output logic [31:0] sram_address,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
   input  logic        sram_ready
);

   localparam int SETS = 1 << SET_BITS;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RD_MISS = 2'd1;
   localparam logic [1:0] S_WR_THRU = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [SETS-1:0]     valid0_q, valid0_d, valid1_q, valid1_d;
   logic [SETS-1:0]     lru_q, lru_d;
   logic [TAG_W-1:0]    tag0_q [SETS];
   logic [TAG_W-1:0]    tag0_d [SETS];
   logic [TAG_W-1:0]    tag1_q [SETS];
   logic [TAG_W-1:0]    tag1_d [SETS];
   logic [31:0]         data0_q [SETS];
   logic [31:0]         data0_d [SETS];
   logic [31:0]         data1_q [SETS];
   logic [31:0]         data1_d [SETS];

   logic [SET_BITS-1:0] idx;
   logic [TAG_W-1:0]    tag;
   logic                hit0, hit1, hit, victim, freeze_raw;
   logic                unused_addr_bits;

   assign idx              = address[SET_BITS+1:2];
   assign tag              = address[18:SET_BITS+2];
   assign unused_addr_bits = ^{address[31:19], address[1:0]};

   assign hit0   = valid0_q[idx] && (tag0_q[idx] == tag);
   assign hit1   = valid1_q[idx] && (tag1_q[idx] == tag);
   assign hit    = hit0 || hit1;
   // Invalid way preferred (way0 first), otherwise the least-recently-used one.
   assign victim = !valid0_q[idx] ? 1'b0 : (!valid1_q[idx] ? 1'b1 : lru_q[idx]);

   assign sram_rd_en   = (state_q == S_RD_MISS);
   assign sram_wr_en   = (state_q == S_WR_THRU);
   assign sram_address = address;
   assign sram_wdata   = wdata;
   // The IDLE miss decode is combinational; mask it so reset always releases the pipe.
   assign freeze       = rst && freeze_raw;

   always_comb begin
      state_d    = state_q;
      valid0_d   = valid0_q;
      valid1_d   = valid1_q;
      lru_d      = lru_q;
      tag0_d     = tag0_q;
      tag1_d     = tag1_q;
      data0_d    = data0_q;
      data1_d    = data1_q;
      freeze_raw = 1'b0;
      rdata      = 32'h0;
      case (state_q)
         S_IDLE: begin
            if (mem_w_en) begin
               state_d    = S_WR_THRU;
               freeze_raw = 1'b1;
            end else if (mem_r_en) begin
               if (hit) begin
                  rdata      = hit0 ? data0_q[idx] : data1_q[idx];
                  lru_d[idx] = hit0;
               end else begin
                  state_d    = S_RD_MISS;
                  freeze_raw = 1'b1;
               end
            end
         end
         S_RD_MISS: begin
            if (sram_ready) begin
               rdata      = sram_rdata;
               lru_d[idx] = ~victim;
               state_d    = S_IDLE;
               if (victim) begin
                  valid1_d[idx] = 1'b1;
                  tag1_d[idx]   = tag;
                  data1_d[idx]  = sram_rdata;
               end else begin
                  valid0_d[idx] = 1'b1;
                  tag0_d[idx]   = tag;
                  data0_d[idx]  = sram_rdata;
               end
            end else begin
               freeze_raw = 1'b1;
            end
         end
         S_WR_THRU: begin
            if (sram_ready) begin
               state_d = S_IDLE;
               if (hit0) begin
                  data0_d[idx] = wdata;
                  lru_d[idx]   = 1'b1;
               end else if (hit1) begin
                  data1_d[idx] = wdata;
                  lru_d[idx]   = 1'b0;
               end
            end else begin
               freeze_raw = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         valid0_q <= '0;
         valid1_q <= '0;
         lru_q    <= '0;
         for (int i = 0; i < SETS; i++) begin
            tag0_q[i]  <= '0;
            tag1_q[i]  <= '0;
            data0_q[i] <= '0;
            data1_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         valid0_q <= valid0_d;
         valid1_q <= valid1_d;
         lru_q    <= lru_d;
         tag0_q   <= tag0_d;
         tag1_q   <= tag1_d;
         data0_q  <= data0_d;
         data1_q  <= data1_d;
      end
   end

endmodule
`default_nettype wire
